// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
// Shared constants, FSM state encoding and the round-robin wrap helper for
// the register-file write arbiter.
//   RF_AW / RF_DW / RF_DEPTH : register file address width, data width, depth
//   GNT_IDX_W                : width of requester indices (up to 8 requesters)
//   arb_state_e              : IDLE / CLEAR
//   rr_wrap()                : (base + off) mod n, used for pointer arithmetic
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

   localparam int unsigned RF_AW     = 3;
   localparam int unsigned RF_DW     = 8;
   localparam int unsigned RF_DEPTH  = 8;
   localparam int unsigned GNT_IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_e;

   // Modulo-n wrap of a requester index; n never exceeds 8 so the result fits.
   function automatic logic [GNT_IDX_W-1:0] rr_wrap(
      input logic [GNT_IDX_W-1:0] base,
      input int unsigned          off,
      input int unsigned          n
   );
      int unsigned sum;
      sum = 32'(base) + off;
      return GNT_IDX_W'(sum % n);
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_arb_if
// Bundles the requester handshake and the register-file write port.
//   req_valid [N_REQ]        : per-requester write request
//   req_addr  [3*N_REQ]      : packed addresses, requester i at [3i+2:3i]
//   req_data  [8*N_REQ]      : packed data, requester i at [8i+7:8i]
//   req_ready [N_REQ]        : one-hot grant back to the requesters
//   rf_we / rf_wa / rf_wd    : write port toward the register file
// Modports: master = requester side (also observes the write port),
//           slave  = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_arb_if
   import regfile_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4
);

   logic [N_REQ-1:0]       req_valid;
   logic [RF_AW*N_REQ-1:0] req_addr;
   logic [RF_DW*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   rf_we;
   logic [RF_AW-1:0]       rf_wa;
   logic [RF_DW-1:0]       rf_wd;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, rf_we, rf_wa, rf_wd
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, rf_we, rf_wa, rf_wd
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker: selects the first valid requester at or
// after ptr_i, wrapping modulo N_REQ.
//   valid_i [N_REQ] : request vector
//   ptr_i   [3]     : highest-priority requester this cycle
//   gnt_o   [N_REQ] : one-hot winner, zero when nothing is valid
//   idx_o   [3]     : winner index (0 when nothing is valid)
//   any_o           : a winner exists
// ---------------------------------------------------------------------------
module rr_picker
   import regfile_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]     valid_i,
   input  logic [GNT_IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0]     gnt_o,
   output logic [GNT_IDX_W-1:0] idx_o,
   output logic                 any_o
);

   // Scan priority ranks k = 0..N_REQ-1; rank k maps to requester (ptr+k) mod N.
   always_comb begin
      gnt_o = {N_REQ{1'b0}};
      idx_o = {GNT_IDX_W{1'b0}};
      any_o = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any_o && valid_i[i] &&
                (rr_wrap(ptr_i, k, N_REQ) == GNT_IDX_W'(i))) begin
               gnt_o[i] = 1'b1;
               idx_o    = GNT_IDX_W'(i);
               any_o    = 1'b1;
            end else begin
               any_o    = any_o;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port among N_REQ requesters with
// round-robin arbitration, plus an optional clear sequencer that writes
// CLEAR_VAL to all eight registers.
// Optional feature macro: REGFILE_ARB_CLEAR_EN (clear sequencer compiled in
// when defined; otherwise clr_start is ignored and clr_busy/clr_done are 0).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : requester handshake in, one-hot req_ready out,
//                  registered rf_we/rf_wa/rf_wd out
//   clr_start_i  : one-cycle clear request
//   clr_busy_o   : clear sequencer active
//   clr_done_o   : one-cycle pulse after the last clear write
//   last_gnt_o   : index of the most recently accepted requester
// ---------------------------------------------------------------------------
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned      N_REQ     = 4,
   parameter logic [RF_DW-1:0] CLEAR_VAL = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_arb_if.slave         bus,
   input  logic                 clr_start_i,
   output logic                 clr_busy_o,
   output logic                 clr_done_o,
   output logic [GNT_IDX_W-1:0] last_gnt_o
);

   arb_state_e             state_q, state_d;
   logic [GNT_IDX_W-1:0]   ptr_q, ptr_d;
   logic                   rf_we_q, rf_we_d;
   logic [RF_AW-1:0]       rf_wa_q, rf_wa_d;
   logic [RF_DW-1:0]       rf_wd_q, rf_wd_d;
   logic [GNT_IDX_W-1:0]   last_gnt_q, last_gnt_d;
   logic                   clr_done_q, clr_done_d;

   logic [N_REQ-1:0]       pick_gnt_s;
   logic [GNT_IDX_W-1:0]   pick_idx_s;
   logic                   pick_any_s;
   logic [N_REQ-1:0]       ready_s;
   logic [RF_AW-1:0]       sel_addr_s;
   logic [RF_DW-1:0]       sel_data_s;
   logic                   clr_start_en_s;

`ifdef REGFILE_ARB_CLEAR_EN
   logic [RF_AW-1:0]       cnt_q, cnt_d;

   assign clr_start_en_s = clr_start_i;
   assign clr_busy_o     = (state_q == ST_CLEAR);
`else
   logic                   unused_clr_s;

   assign clr_start_en_s = 1'b0;
   assign unused_clr_s   = ^{clr_start_i, CLEAR_VAL};
   assign clr_busy_o     = 1'b0;
`endif

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .valid_i (bus.req_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt_s),
      .idx_o   (pick_idx_s),
      .any_o   (pick_any_s)
   );

   // AND-OR mux of the winning requester's address and data.
   always_comb begin
      sel_addr_s = {RF_AW{1'b0}};
      sel_data_s = {RF_DW{1'b0}};
      for (int unsigned i = 0; i < N_REQ; i++) begin
         sel_addr_s |= {RF_AW{pick_gnt_s[i]}} & bus.req_addr[i*RF_AW +: RF_AW];
         sel_data_s |= {RF_DW{pick_gnt_s[i]}} & bus.req_data[i*RF_DW +: RF_DW];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic and clear counter advance.
   always_comb begin
      state_d = state_q;
`ifdef REGFILE_ARB_CLEAR_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (clr_start_en_s) begin
               state_d = ST_CLEAR;
`ifdef REGFILE_ARB_CLEAR_EN
               cnt_d   = {RF_AW{1'b0}};
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef REGFILE_ARB_CLEAR_EN
         ST_CLEAR: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == RF_AW'(RF_DEPTH - 1)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CLEAR;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: grant, next write-port contents, pointer and status updates.
   always_comb begin
      ready_s    = {N_REQ{1'b0}};
      rf_we_d    = 1'b0;
      rf_wa_d    = rf_wa_q;
      rf_wd_d    = rf_wd_q;
      ptr_d      = ptr_q;
      last_gnt_d = last_gnt_q;
      clr_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A clear request masks all grants so the clear wins this cycle.
            if (clr_start_en_s) begin
               ready_s = {N_REQ{1'b0}};
            end else if (pick_any_s) begin
               ready_s    = pick_gnt_s;
               rf_we_d    = 1'b1;
               rf_wa_d    = sel_addr_s;
               rf_wd_d    = sel_data_s;
               ptr_d      = rr_wrap(pick_idx_s, 1, N_REQ);
               last_gnt_d = pick_idx_s;
            end else begin
               ready_s = {N_REQ{1'b0}};
            end
         end
`ifdef REGFILE_ARB_CLEAR_EN
         ST_CLEAR: begin
            rf_we_d = 1'b1;
            rf_wa_d = cnt_q;
            rf_wd_d = CLEAR_VAL;
            if (cnt_q == RF_AW'(RF_DEPTH - 1)) begin
               clr_done_d = 1'b1;
            end else begin
               clr_done_d = 1'b0;
            end
         end
`endif
         default: begin
            ready_s = {N_REQ{1'b0}};
         end
      endcase
   end

   // Registered write port, arbitration pointer and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= {GNT_IDX_W{1'b0}};
         rf_we_q    <= 1'b0;
         rf_wa_q    <= {RF_AW{1'b0}};
         rf_wd_q    <= {RF_DW{1'b0}};
         last_gnt_q <= {GNT_IDX_W{1'b0}};
         clr_done_q <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         rf_we_q    <= rf_we_d;
         rf_wa_q    <= rf_wa_d;
         rf_wd_q    <= rf_wd_d;
         last_gnt_q <= last_gnt_d;
         clr_done_q <= clr_done_d;
      end
   end

`ifdef REGFILE_ARB_CLEAR_EN
   // Clear address counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {RF_AW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign bus.req_ready = ready_s;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wa     = rf_wa_q;
   assign bus.rf_wd     = rf_wd_q;
   assign clr_done_o    = clr_done_q;
   assign last_gnt_o    = last_gnt_q;

endmodule
